// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between the instruction and data requesters.
// One transaction in flight at a time; request and response are registered, with a BUSY timeout.
module mem_port_arbiter #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_request,
  input  logic                    i_we_re,
  input  logic [DATA_WIDTH/8-1:0] i_mask,
  input  logic [ADDR_WIDTH-1:0]   i_address,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  output logic                    i_valid,
  output logic [DATA_WIDTH-1:0]   i_rdata,
  input  logic                    d_request,
  input  logic                    d_we_re,
  input  logic [DATA_WIDTH/8-1:0] d_mask,
  input  logic [ADDR_WIDTH-1:0]   d_address,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  output logic                    d_valid,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic                    mem_request,
  output logic                    mem_we_re,
  output logic [DATA_WIDTH/8-1:0] mem_mask,
  output logic [ADDR_WIDTH-1:0]   mem_address,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic                    mem_valid,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic                    resp_err,
  output logic                    grant_d
);

  localparam int unsigned MASK_W = DATA_WIDTH / 8;
  localparam int unsigned CNT_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  state_e                state_q, state_d;
  logic                  grant_d_q, grant_d_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  mem_request_q, mem_request_d;
  logic                  mem_we_re_q, mem_we_re_d;
  logic [MASK_W-1:0]     mem_mask_q, mem_mask_d;
  logic [ADDR_WIDTH-1:0] mem_address_q, mem_address_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  i_valid_q, i_valid_d;
  logic                  d_valid_q, d_valid_d;
  logic [DATA_WIDTH-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
  logic                  resp_err_q, resp_err_d;
  logic                  gnt_c;
  logic                  finish_c;
  logic                  timeout_c;
  logic [DATA_WIDTH-1:0] resp_data_c;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      grant_d_q     <= 1'b0;
      cnt_q         <= '0;
      mem_request_q <= 1'b0;
      mem_we_re_q   <= 1'b0;
      mem_mask_q    <= '0;
      mem_address_q <= '0;
      mem_wdata_q   <= '0;
      i_valid_q     <= 1'b0;
      d_valid_q     <= 1'b0;
      i_rdata_q     <= '0;
      d_rdata_q     <= '0;
      resp_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_d_q     <= grant_d_d;
      cnt_q         <= cnt_d;
      mem_request_q <= mem_request_d;
      mem_we_re_q   <= mem_we_re_d;
      mem_mask_q    <= mem_mask_d;
      mem_address_q <= mem_address_d;
      mem_wdata_q   <= mem_wdata_d;
      i_valid_q     <= i_valid_d;
      d_valid_q     <= d_valid_d;
      i_rdata_q     <= i_rdata_d;
      d_rdata_q     <= d_rdata_d;
      resp_err_q    <= resp_err_d;
    end
  end

  // grant_d_q doubles as last_grant: both follow every grant and reset to instruction
  always_comb begin
    state_d       = state_q;
    grant_d_d     = grant_d_q;
    cnt_d         = cnt_q;
    mem_request_d = mem_request_q;
    mem_we_re_d   = mem_we_re_q;
    mem_mask_d    = mem_mask_q;
    mem_address_d = mem_address_q;
    mem_wdata_d   = mem_wdata_q;
    i_valid_d     = 1'b0;
    d_valid_d     = 1'b0;
    i_rdata_d     = i_rdata_q;
    d_rdata_d     = d_rdata_q;
    resp_err_d    = 1'b0;
    gnt_c         = (i_request && d_request) ? !grant_d_q : d_request;
    timeout_c     = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);
    finish_c      = 1'b0;
    resp_data_c   = '0;

    case (state_q)
      IDLE: begin
        if (i_request || d_request) begin
          state_d       = BUSY;
          grant_d_d     = gnt_c;
          cnt_d         = '0;
          mem_request_d = 1'b1;
          mem_we_re_d   = gnt_c ? d_we_re   : i_we_re;
          mem_mask_d    = gnt_c ? d_mask    : i_mask;
          mem_address_d = gnt_c ? d_address : i_address;
          mem_wdata_d   = gnt_c ? d_wdata   : i_wdata;
        end
      end
      BUSY: begin
        // A completion in the timeout cycle still counts as a good response
        if (mem_valid) begin
          finish_c    = 1'b1;
          resp_data_c = mem_rdata;
        end else if (timeout_c) begin
          finish_c    = 1'b1;
          resp_err_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (finish_c) begin
          state_d       = RESP;
          mem_request_d = 1'b0;
          if (grant_d_q) begin
            d_valid_d = 1'b1;
            d_rdata_d = resp_data_c;
          end else begin
            i_valid_d = 1'b1;
            i_rdata_d = resp_data_c;
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign i_valid     = i_valid_q;
  assign i_rdata     = i_rdata_q;
  assign d_valid     = d_valid_q;
  assign d_rdata     = d_rdata_q;
  assign mem_request = mem_request_q;
  assign mem_we_re   = mem_we_re_q;
  assign mem_mask    = mem_mask_q;
  assign mem_address = mem_address_q;
  assign mem_wdata   = mem_wdata_q;
  assign resp_err    = resp_err_q;
  assign grant_d     = grant_d_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model of arbitration, timeout and response routing.
module tb_mem_port_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned MW = DW / 8;
  localparam int unsigned TO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_request, i_we_re, d_request, d_we_re;
  logic [MW-1:0] i_mask, d_mask, mem_mask;
  logic [AW-1:0] i_address, d_address, mem_address;
  logic [DW-1:0] i_wdata, d_wdata, mem_wdata, i_rdata, d_rdata, mem_rdata;
  logic          i_valid, d_valid, mem_request, mem_we_re, mem_valid, resp_err, grant_d;

  int errors = 0;
  int checks = 0;

  // Observations collected by the memory-side driver for one transaction
  bit            obs_got;
  logic          obs_gd, obs_we, obs_err;
  logic [MW-1:0] obs_mask;
  logic [AW-1:0] obs_addr;
  logic [DW-1:0] obs_wdata, obs_rdata, obs_other;
  int            obs_cycles, obs_iv, obs_dv;

  // Reference model state
  logic          model_last;
  logic [DW-1:0] exp_i_rdata, exp_d_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .i_request(i_request), .i_we_re(i_we_re), .i_mask(i_mask), .i_address(i_address),
    .i_wdata(i_wdata), .i_valid(i_valid), .i_rdata(i_rdata),
    .d_request(d_request), .d_we_re(d_we_re), .d_mask(d_mask), .d_address(d_address),
    .d_wdata(d_wdata), .d_valid(d_valid), .d_rdata(d_rdata),
    .mem_request(mem_request), .mem_we_re(mem_we_re), .mem_mask(mem_mask),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_valid(mem_valid),
    .mem_rdata(mem_rdata), .resp_err(resp_err), .grant_d(grant_d)
  );

  function automatic logic model_grant(input logic ireq, input logic dreq, input logic last);
    if (ireq && dreq) return !last;
    return dreq;
  endfunction

  // lat = BUSY cycle (1-based) in which memory completes; 0 or beyond the timeout = never
  function automatic logic model_err(input int lat);
    return (lat < 1) || (lat > int'(TO));
  endfunction

  function automatic int model_cycles(input int lat);
    return model_err(lat) ? int'(TO) : lat;
  endfunction

  task automatic do_reset();
    rst = 1'b0;
    mem_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    model_last  = 1'b0;
    exp_i_rdata = '0;
    exp_d_rdata = '0;
  endtask

  // Memory-side driver: waits for a grant, completes it at BUSY cycle lat, records outputs
  task automatic serve(input int lat, input logic [DW-1:0] rd, input bit keep);
    int w = 0;
    obs_got = 0; obs_cycles = 0; obs_iv = 0; obs_dv = 0;
    while (!mem_request && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!mem_request) return;
    obs_got   = 1;
    obs_gd    = grant_d;
    obs_we    = mem_we_re;
    obs_mask  = mem_mask;
    obs_addr  = mem_address;
    obs_wdata = mem_wdata;
    while (mem_request && obs_cycles < 20) begin
      obs_cycles++;
      mem_valid = (obs_cycles == lat);
      mem_rdata = (obs_cycles == lat) ? rd : DW'($urandom);
      @(negedge clk);
    end
    mem_valid = 1'b0;
    obs_iv    = int'(i_valid);
    obs_dv    = int'(d_valid);
    obs_err   = resp_err;
    obs_rdata = obs_gd ? d_rdata : i_rdata;
    obs_other = obs_gd ? i_rdata : d_rdata;
    if (!keep) begin
      if (obs_gd) d_request = 1'b0;
      else        i_request = 1'b0;
    end
    @(negedge clk);
    obs_iv += int'(i_valid);
    obs_dv += int'(d_valid);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    i_request = 0; i_we_re = 0; i_mask = '0; i_address = '0; i_wdata = '0;
    d_request = 0; d_we_re = 0; d_mask = '0; d_address = '0; d_wdata = '0;
    mem_valid = 0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({mem_request, i_valid, d_valid, resp_err, grant_d} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 00000",
               {mem_request, i_valid, d_valid, resp_err, grant_d});
    end
    checks++;
    if ({i_rdata, d_rdata, mem_address, mem_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_data: got i_rdata=%h d_rdata=%h addr=%h wdata=%h expected all 0",
               i_rdata, d_rdata, mem_address, mem_wdata);
    end
    do_reset();
  endtask

  task automatic test_single_read();
    i_we_re = 0; i_mask = 4'hF; i_address = 32'h100; i_wdata = '0;
    i_request = 1;
    serve(3, 32'h0000_0013, 0);
    checks++;
    if (!obs_got || obs_gd !== 1'b0 || obs_addr !== 32'h100 || obs_we !== 1'b0) begin
      errors++;
      $display("FAIL single_grant: got=%0d gd=%b addr=%h we=%b expected 1 0 100 0",
               obs_got, obs_gd, obs_addr, obs_we);
    end
    checks++;
    if (obs_iv != 1 || obs_dv != 0) begin
      errors++;
      $display("FAIL single_pulses: i_valid=%0d d_valid=%0d expected 1 0", obs_iv, obs_dv);
    end
    checks++;
    if (obs_rdata !== 32'h13 || obs_err !== 1'b0) begin
      errors++;
      $display("FAIL single_resp: rdata=%h err=%b expected 00000013 0", obs_rdata, obs_err);
    end
  endtask

  task automatic test_tie();
    do_reset();
    i_we_re = 0; i_mask = 4'hF; i_address = 32'h200; i_wdata = '0;
    d_we_re = 1; d_mask = 4'hF; d_address = 32'h8000; d_wdata = 32'hDEAD_BEEF;
    i_request = 1; d_request = 1;
    serve(2, 32'h0, 0);
    checks++;
    if (!obs_got || obs_gd !== 1'b1 || obs_we !== 1'b1 || obs_wdata !== 32'hDEAD_BEEF ||
        obs_addr !== 32'h8000 || obs_mask !== 4'hF) begin
      errors++;
      $display("FAIL tie_first: gd=%b we=%b wdata=%h addr=%h mask=%h expected 1 1 deadbeef 8000 f",
               obs_gd, obs_we, obs_wdata, obs_addr, obs_mask);
    end
    checks++;
    if (obs_dv != 1 || obs_iv != 0) begin
      errors++;
      $display("FAIL tie_first_pulse: d_valid=%0d i_valid=%0d expected 1 0", obs_dv, obs_iv);
    end
    serve(1, 32'h1234, 0);
    checks++;
    if (!obs_got || obs_gd !== 1'b0 || obs_addr !== 32'h200 || obs_iv != 1 || obs_dv != 0 ||
        obs_rdata !== 32'h1234) begin
      errors++;
      $display("FAIL tie_second: gd=%b addr=%h iv=%0d dv=%0d rdata=%h expected 0 200 1 0 1234",
               obs_gd, obs_addr, obs_iv, obs_dv, obs_rdata);
    end
  endtask

  task automatic test_round_robin();
    logic exp_gd;
    do_reset();
    i_we_re = 0; i_address = 32'h400; d_we_re = 0; d_address = 32'h9000;
    i_request = 1; d_request = 1;
    for (int k = 0; k < 6; k++) begin
      exp_gd = model_grant(1'b1, 1'b1, model_last);
      serve(2, DW'(k), 1);
      checks++;
      if (!obs_got || obs_gd !== exp_gd || obs_iv != int'(!exp_gd) || obs_dv != int'(exp_gd)) begin
        errors++;
        $display("FAIL rr_%0d: gd=%b iv=%0d dv=%0d expected gd=%b", k, obs_gd, obs_iv, obs_dv,
                 exp_gd);
      end
      model_last = exp_gd;
    end
    i_request = 0; d_request = 0;
    repeat (4) @(negedge clk);
    checks++;
    if (mem_request !== 1'b0) begin
      errors++;
      $display("FAIL rr_idle: mem_request=%b expected 0", mem_request);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    d_we_re = 0; d_address = 32'hA000; d_request = 1;
    serve(0, 32'h0, 0);
    checks++;
    if (!obs_got || obs_cycles != int'(TO)) begin
      errors++;
      $display("FAIL timeout_len: got=%0d busy_cycles=%0d expected %0d", obs_got, obs_cycles, TO);
    end
    checks++;
    if (obs_dv != 1 || obs_iv != 0 || obs_err !== 1'b1 || obs_rdata !== '0) begin
      errors++;
      $display("FAIL timeout_resp: dv=%0d iv=%0d err=%b rdata=%h expected 1 0 1 0",
               obs_dv, obs_iv, obs_err, obs_rdata);
    end
    checks++;
    if (resp_err !== 1'b0 || mem_request !== 1'b0) begin
      errors++;
      $display("FAIL timeout_idle: resp_err=%b mem_request=%b expected 0 0", resp_err, mem_request);
    end
  endtask

  task automatic test_collision();
    d_address = 32'hA004; d_request = 1;
    serve(int'(TO), 32'h55, 0);
    checks++;
    if (!obs_got || obs_cycles != int'(TO) || obs_err !== 1'b0 || obs_rdata !== 32'h55 ||
        obs_dv != 1) begin
      errors++;
      $display("FAIL collision: cycles=%0d err=%b rdata=%h dv=%0d expected %0d 0 55 1",
               obs_cycles, obs_err, obs_rdata, obs_dv, TO);
    end
  endtask

  task automatic test_reset_mid_busy();
    int w = 0;
    do_reset();
    i_we_re = 0; i_address = 32'h300; i_request = 1;
    while (!mem_request && w < 20) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);
    checks++;
    if (mem_request !== 1'b1) begin
      errors++;
      $display("FAIL midrst_busy: mem_request=%b expected 1", mem_request);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (mem_request !== 1'b0 || mem_address !== '0) begin
      errors++;
      $display("FAIL midrst_async: mem_request=%b addr=%h expected 0 0", mem_request, mem_address);
    end
    mem_valid = 1'b1; mem_rdata = 32'hBAD;
    @(negedge clk);
    mem_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (i_valid !== 1'b0 || d_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_novalid: i_valid=%b d_valid=%b expected 0 0", i_valid, d_valid);
    end
    rst = 1'b1;
    model_last = 1'b0;
    serve(1, 32'h77, 0);
    checks++;
    if (!obs_got || obs_gd !== 1'b0 || obs_addr !== 32'h300 || obs_iv != 1 ||
        obs_rdata !== 32'h77 || obs_err !== 1'b0) begin
      errors++;
      $display("FAIL midrst_regrant: got=%0d gd=%b addr=%h iv=%0d rdata=%h err=%b",
               obs_got, obs_gd, obs_addr, obs_iv, obs_rdata, obs_err);
    end
  endtask

  task automatic test_random();
    logic          exp_gd, exp_we, exp_err;
    logic [MW-1:0] exp_mask;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wdata, exp_data, exp_other, rd;
    int            lat;
    do_reset();
    for (int n = 0; n < 40; n++) begin
      if (!i_request && $urandom_range(0, 1) == 1) begin
        i_we_re = 1'($urandom); i_mask = MW'($urandom); i_address = AW'($urandom);
        i_wdata = DW'($urandom); i_request = 1;
      end
      if (!d_request && $urandom_range(0, 1) == 1) begin
        d_we_re = 1'($urandom); d_mask = MW'($urandom); d_address = AW'($urandom);
        d_wdata = DW'($urandom); d_request = 1;
      end
      if (!i_request && !d_request) begin
        d_we_re = 1; d_mask = MW'($urandom); d_address = AW'($urandom);
        d_wdata = DW'($urandom); d_request = 1;
      end
      exp_gd    = model_grant(i_request, d_request, model_last);
      exp_we    = exp_gd ? d_we_re   : i_we_re;
      exp_mask  = exp_gd ? d_mask    : i_mask;
      exp_addr  = exp_gd ? d_address : i_address;
      exp_wdata = exp_gd ? d_wdata   : i_wdata;
      lat       = $urandom_range(0, TO + 1);
      rd        = DW'($urandom);
      exp_err   = model_err(lat);
      exp_data  = exp_err ? '0 : rd;
      exp_other = exp_gd ? exp_i_rdata : exp_d_rdata;
      serve(lat, rd, 0);
      checks++;
      if (!obs_got || obs_gd !== exp_gd || obs_we !== exp_we || obs_mask !== exp_mask ||
          obs_addr !== exp_addr || obs_wdata !== exp_wdata) begin
        errors++;
        $display("FAIL rand_req_%0d: gd=%b we=%b mask=%h addr=%h wdata=%h expected %b %b %h %h %h",
                 n, obs_gd, obs_we, obs_mask, obs_addr, obs_wdata,
                 exp_gd, exp_we, exp_mask, exp_addr, exp_wdata);
      end
      checks++;
      if (obs_cycles != model_cycles(lat) || obs_err !== exp_err || obs_rdata !== exp_data ||
          obs_iv != int'(!exp_gd) || obs_dv != int'(exp_gd) || obs_other !== exp_other) begin
        errors++;
        $display("FAIL rand_resp_%0d: cyc=%0d err=%b rdata=%h iv=%0d dv=%0d other=%h exp cyc=%0d err=%b rdata=%h other=%h",
                 n, obs_cycles, obs_err, obs_rdata, obs_iv, obs_dv, obs_other,
                 model_cycles(lat), exp_err, exp_data, exp_other);
      end
      model_last = exp_gd;
      if (exp_gd) exp_d_rdata = exp_data;
      else        exp_i_rdata = exp_data;
    end
    i_request = 0; d_request = 0;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_tie();
    test_round_robin();
    test_timeout();
    test_collision();
    test_reset_mid_busy();
    test_random();
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one unified memory port between the core's instruction-fetch requester and its data (load/store) requester. Sits between the pipeline core and a single-ported memory. Grants one outstanding transaction at a time with round-robin arbitration. Registers the outgoing request and the returned response, and bounds each transaction with a timeout.

Parameters:
ADDR_WIDTH, 32, width of all address buses
DATA_WIDTH, 32, width of data buses; mask width is DATA_WIDTH/8
TIMEOUT_CYCLES, 64, BUSY cycles without mem_valid before the transaction is aborted; 0 disables the timeout

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
i_request  in  1  instruction requester holds high until its i_valid pulse
i_we_re  in  1  1=write, 0=read
i_mask  in  DATA_WIDTH/8  byte enables
i_address  in  ADDR_WIDTH  instruction address
i_wdata  in  DATA_WIDTH  write data
i_valid  out  1  one-cycle response pulse to the instruction requester
i_rdata  out  DATA_WIDTH  response data, valid with i_valid
d_request, d_we_re, d_mask, d_address, d_wdata  in  as for the i_* inputs  data requester
d_valid  out  1  one-cycle response pulse to the data requester
d_rdata  out  DATA_WIDTH  response data, valid with d_valid
mem_request  out  1  request to memory, held until mem_valid or timeout
mem_we_re  out  1  registered copy of the granted requester's i_we_re/d_we_re
mem_mask  out  DATA_WIDTH/8  registered copy of the granted mask
mem_address  out  ADDR_WIDTH  registered copy of the granted address
mem_wdata  out  DATA_WIDTH  registered copy of the granted write data
mem_valid  in  1  memory completion strobe
mem_rdata  in  DATA_WIDTH  memory read data, sampled on mem_valid
resp_err  out  1  high with i_valid/d_valid when the transaction timed out
grant_d  out  1  owner of the current/last transaction (1=data, 0=instruction)

Behaviour:
- rst low, asynchronous: state=IDLE, all outputs 0, timeout counter 0, last_grant=instruction. Reset asserted mid-transaction drops mem_request immediately; the response is lost and no valid pulse is produced.
- Requester contract: request and its fields stay stable from assertion until the matching valid pulse. mem_* fields stay stable while mem_request=1.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - No request: stay in IDLE.
  - One requester active: grant it.
  - Both active: grant the requester not in last_grant. After reset, data wins the first tie.
  - On a grant: next cycle state=BUSY, mem_request=1, mem_* loaded from the granted port, grant_d and last_grant updated, counter cleared.
- BUSY:
  - mem_valid=1: capture mem_rdata, set resp_err=0, mem_request=0, go to RESP. Read data is captured for writes too.
  - Otherwise the counter increments. When counter==TIMEOUT_CYCLES-1 and mem_valid=0: mem_request=0, captured data=0, resp_err=1, go to RESP.
  - mem_valid in the same cycle as the timeout: mem_valid wins, resp_err=0.
- RESP (exactly one cycle):
  - Pulse the granted port's valid with the captured rdata. The other port's valid stays 0, and its rdata holds its last value.
  - Requests are ignored in this cycle. Next state is IDLE.
- Latency: request seen at cycle N; mem_request rises at N+1; mem_valid at cycle M≥N+1; valid pulse at M+1; earliest new grant decision at M+2. Minimum 3 cycles per transaction.
- A requester that keeps its request high after its valid pulse starts a new transaction, arbitrated normally against the other port.
- A port's valid never rises without a prior grant to that port.
- Outside RESP, i_valid, d_valid and resp_err are 0.

Test Plan:
- Single instruction read: i_request=1, i_address=0x100; mem_valid two cycles after mem_request with mem_rdata=0x00000013 -> mem_address=0x100 with mem_we_re=0; i_valid pulses once with i_rdata=0x00000013 and resp_err=0; d_valid stays 0.
- Simultaneous requests after reset: i_address=0x200, d_address=0x8000 store with d_wdata=0xDEADBEEF, d_mask=0xF -> data port served first (mem_we_re=1, mem_wdata=0xDEADBEEF); instruction served next; d_valid precedes i_valid.
- Round-robin under continuous load: both requests held high for 6 transactions -> grant_d sequence 1,0,1,0,1,0; neither port starves.
- Timeout: TIMEOUT_CYCLES=4, d_request=1, mem_valid never asserts -> mem_request high for exactly 4 cycles; d_valid=1 with resp_err=1 and d_rdata=0; FSM returns to IDLE.
- Timeout collision: mem_valid arrives in the 4th BUSY cycle with mem_rdata=0x55 -> resp_err=0, rdata=0x55.
- Reset mid-BUSY: rst low while mem_request=1 -> mem_request=0 asynchronously; no valid pulse; after rst returns high, a held i_request is re-granted cleanly.
